// File: rtl/sha512_core_arbiter.sv
// Round-robin arbiter that lends one SHA-512 core to NUM_REQ requesters for whole messages.
// Optional owner-stall timeout is built only when SHA_ARB_TIMEOUT_EN is defined.
module sha512_core_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned OWNER_W        = 1,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_REQ-1:0]      req_valid_i,
  input  logic [NUM_REQ-1:0]      req_first_i,
  input  logic [NUM_REQ-1:0]      req_last_i,
  input  logic [NUM_REQ*1024-1:0] req_block_i,
  output logic [NUM_REQ-1:0]      req_ready_o,
  output logic [NUM_REQ-1:0]      rsp_valid_o,
  output logic [NUM_REQ-1:0]      rsp_abort_o,
  output logic [511:0]            rsp_digest_o,
  output logic                    busy_o,
  output logic [OWNER_W-1:0]      owner_o,
  output logic                    sha_init_o,
  output logic                    sha_next_o,
  output logic [1023:0]           sha_block_o,
  input  logic [511:0]            sha_digest_i,
  input  logic                    sha_digest_valid_i,
  input  logic                    sha_ready_i
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || OWNER_W != $clog2(NUM_REQ) || TIMEOUT_CYCLES < 1)
  begin : g_param_check
    $error("sha512_core_arbiter: illegal NUM_REQ/OWNER_W/TIMEOUT_CYCLES combination");
  end

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_RESP} state_e;

  state_e             state_q, state_d;
  logic [OWNER_W-1:0] owner_q, owner_d;
  logic [OWNER_W-1:0] ptr_q, ptr_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic [511:0]       digest_q, digest_d;

  logic               fire;
  logic               timeout_hit;
  logic [NUM_REQ-1:0] eligible;
  logic               grant_found;
  logic [OWNER_W-1:0] grant_idx;

  assign eligible = req_valid_i & req_first_i;
  assign fire     = (state_q == S_ISSUE) && sha_ready_i && req_valid_i[owner_q];

  // Search starts one past the last owner and wraps, giving strict round-robin.
  always_comb begin : arb
    int unsigned idx;
    grant_found = 1'b0;
    grant_idx   = '0;
    idx         = 0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!grant_found && eligible[OWNER_W'(idx)]) begin
        grant_found = 1'b1;
        grant_idx   = OWNER_W'(idx);
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    first_d  = first_q;
    last_d   = last_q;
    digest_d = digest_q;
    case (state_q)
      S_IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          first_d = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (fire) begin
          last_d  = req_last_i[owner_q];
          first_d = 1'b0;
          state_d = S_BUSY;
        end else if (timeout_hit) begin
          ptr_d   = owner_q;
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (sha_digest_valid_i) begin
          if (last_q) begin
            digest_d = sha_digest_i;
            state_d  = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_RESP: begin
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      owner_q  <= '0;
      ptr_q    <= OWNER_W'(NUM_REQ - 1);
      first_q  <= 1'b0;
      last_q   <= 1'b0;
      digest_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      first_q  <= first_d;
      last_q   <= last_d;
      digest_q <= digest_d;
    end
  end

`ifdef SHA_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] abort_q, abort_d;

  // Only stalls between blocks count; waiting for the core before the first block never times out.
  always_comb begin
    cnt_d       = '0;
    abort_d     = '0;
    timeout_hit = 1'b0;
    if (state_q == S_ISSUE && !fire && !first_q) begin
      if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
        timeout_hit      = 1'b1;
        abort_d[owner_q] = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      abort_q <= '0;
    end else begin
      cnt_q   <= cnt_d;
      abort_q <= abort_d;
    end
  end

  assign rsp_abort_o = abort_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_abort_o = '0;
`endif

  assign sha_init_o   = fire & first_q;
  assign sha_next_o   = fire & ~first_q;
  assign sha_block_o  = fire ? req_block_i[32'(owner_q)*1024 +: 1024] : '0;
  assign req_ready_o  = fire ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_valid_o  = (state_q == S_RESP) ? (NUM_REQ'(1) << owner_q) : '0;
  assign rsp_digest_o = digest_q;
  assign busy_o       = (state_q != S_IDLE);
  assign owner_o      = owner_q;

endmodule

// File: tb/tb_sha512_core_arbiter.sv
// Directed bench for sha512_core_arbiter with two requesters; the timeout scenario
// runs only when SHA_ARB_TIMEOUT_EN is defined.
module tb_sha512_core_arbiter;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req_valid, req_first, req_last;
  logic [2047:0] req_block;
  logic [1:0]    req_ready, rsp_valid, rsp_abort;
  logic [511:0]  rsp_digest;
  logic          busy;
  logic [0:0]    owner;
  logic          sha_init, sha_next;
  logic [1023:0] sha_block;
  logic [511:0]  sha_digest;
  logic          sha_digest_valid, sha_ready;

  int nchecks = 0;
  int nerrors = 0;

  logic [1023:0] blk_a, blk_b1, blk_b2, blk_b3, blk_c0, blk_c1, blk_f0, blk_f1, blk_g;
  logic [511:0]  dig_d, dig_d1, dig_d3, dig_e0, dig_e1;

  sha512_core_arbiter #(
    .NUM_REQ(2),
    .OWNER_W(1),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid_i(req_valid),
    .req_first_i(req_first),
    .req_last_i(req_last),
    .req_block_i(req_block),
    .req_ready_o(req_ready),
    .rsp_valid_o(rsp_valid),
    .rsp_abort_o(rsp_abort),
    .rsp_digest_o(rsp_digest),
    .busy_o(busy),
    .owner_o(owner),
    .sha_init_o(sha_init),
    .sha_next_o(sha_next),
    .sha_block_o(sha_block),
    .sha_digest_i(sha_digest),
    .sha_digest_valid_i(sha_digest_valid),
    .sha_ready_i(sha_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    nchecks++;
    assert (obs === exp)
    else begin
      nerrors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs[127:0], exp[127:0]);
    end
  endtask

  // Strobe/handshake snapshot: {init, next, req_ready, rsp_valid}
  function automatic logic [1023:0] strobes();
    return 1024'({sha_init, sha_next, req_ready, rsp_valid});
  endfunction

  initial begin
    blk_a  = {32{32'hAAAA_0001}};
    blk_b1 = {32{32'hBBBB_0001}};
    blk_b2 = {32{32'hBBBB_0002}};
    blk_b3 = {32{32'hBBBB_0003}};
    blk_c0 = {32{32'hCCCC_0000}};
    blk_c1 = {32{32'hCCCC_0001}};
    blk_f0 = {32{32'hFFFF_0000}};
    blk_f1 = {32{32'hFFFF_0001}};
    blk_g  = {32{32'h6666_0001}};
    dig_d  = {16{32'hD0D0_0001}};
    dig_d1 = {16{32'hD1D1_0001}};
    dig_d3 = {16{32'hD3D3_0003}};
    dig_e0 = {16{32'hE0E0_0000}};
    dig_e1 = {16{32'hE1E1_0001}};

    rst_n = 1'b1;
    req_valid = '0; req_first = '0; req_last = '0; req_block = '0;
    sha_digest = '0; sha_digest_valid = 1'b0; sha_ready = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    // ---- reset state
    chk("rst_busy", 1024'(busy), 1024'(0));
    chk("rst_owner", 1024'(owner), 1024'(0));
    chk("rst_strobes", strobes(), 1024'(0));
    chk("rst_abort", 1024'(rsp_abort), 1024'(0));
    chk("rst_digest", 1024'(rsp_digest), 1024'(0));
    chk("rst_block", sha_block, 1024'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- single-block message from req 0
    req_valid = 2'b01; req_first = 2'b01; req_last = 2'b01;
    req_block[0 +: 1024] = blk_a; sha_ready = 1'b1;
    #1;
    chk("s1_idle_no_strobe", strobes(), 1024'(0));
    tick();
    #1;
    chk("s1_init", strobes(), 1024'({1'b1, 1'b0, 2'b01, 2'b00}));
    chk("s1_block", sha_block, blk_a);
    chk("s1_busy", 1024'(busy), 1024'(1));
    tick();
    req_valid = 2'b00;
    #1;
    chk("s1_busy_no_strobe", strobes(), 1024'(0));
    chk("s1_busy_block0", sha_block, 1024'(0));
    repeat (79) tick();
    sha_digest = dig_d; sha_digest_valid = 1'b1;
    #1;
    chk("s1_no_rsp_yet", 1024'(rsp_valid), 1024'(0));
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s1_rsp_valid", 1024'(rsp_valid), 1024'(2'b01));
    chk("s1_rsp_digest", 1024'(rsp_digest), 1024'(dig_d));
    tick();
    #1;
    chk("s1_rsp_one_cycle", 1024'(rsp_valid), 1024'(0));
    chk("s1_idle_busy", 1024'(busy), 1024'(0));

    // ---- three-block message from req 1, core initially not ready
    req_valid = 2'b10; req_first = 2'b10; req_last = 2'b00;
    req_block[1024 +: 1024] = blk_b1; sha_ready = 1'b0;
    tick();
    #1;
    chk("s2_wait_ready", strobes(), 1024'(0));
    chk("s2_owner", 1024'(owner), 1024'(1));
    tick();
    sha_ready = 1'b1;
    #1;
    chk("s2_init", strobes(), 1024'({1'b1, 1'b0, 2'b10, 2'b00}));
    chk("s2_block1", sha_block, blk_b1);
    tick();
    sha_ready = 1'b0; req_first = 2'b00; req_block[1024 +: 1024] = blk_b2;
    sha_digest = dig_d1; sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s2_mid_no_rsp", strobes(), 1024'(0));
    tick();
    sha_ready = 1'b1;
    #1;
    chk("s2_next1", strobes(), 1024'({1'b0, 1'b1, 2'b10, 2'b00}));
    chk("s2_block2", sha_block, blk_b2);
    tick();
    req_last = 2'b10; req_block[1024 +: 1024] = blk_b3; sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s2_next2", strobes(), 1024'({1'b0, 1'b1, 2'b10, 2'b00}));
    chk("s2_block3", sha_block, blk_b3);
    tick();
    req_valid = 2'b00; sha_digest = dig_d3; sha_digest_valid = 1'b1;
    #1;
    chk("s2_busy_quiet", strobes(), 1024'(0));
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s2_rsp", strobes(), 1024'({1'b0, 1'b0, 2'b00, 2'b10}));
    chk("s2_digest", 1024'(rsp_digest), 1024'(dig_d3));
    tick();

    // ---- simultaneous first requests: req 0 then req 1, then req 0 again
    req_valid = 2'b11; req_first = 2'b11; req_last = 2'b11;
    req_block[0 +: 1024] = blk_c0; req_block[1024 +: 1024] = blk_c1;
    tick();
    #1;
    chk("s3_grant0", strobes(), 1024'({1'b1, 1'b0, 2'b01, 2'b00}));
    chk("s3_block0", sha_block, blk_c0);
    tick();
    req_valid = 2'b10; sha_digest = dig_e0; sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s3_rsp0", strobes(), 1024'({1'b0, 1'b0, 2'b00, 2'b01}));
    chk("s3_digest0", 1024'(rsp_digest), 1024'(dig_e0));
    tick();
    #1;
    chk("s3_idle_quiet", strobes(), 1024'(0));
    tick();
    #1;
    chk("s3_grant1", strobes(), 1024'({1'b1, 1'b0, 2'b10, 2'b00}));
    chk("s3_block1", sha_block, blk_c1);
    tick();
    req_valid = 2'b00; sha_digest = dig_e1; sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0; req_valid = 2'b11; req_first = 2'b11;
    #1;
    chk("s3_rsp1", strobes(), 1024'({1'b0, 1'b0, 2'b00, 2'b10}));
    tick(); tick();
    #1;
    chk("s3_regrant0", strobes(), 1024'({1'b1, 1'b0, 2'b01, 2'b00}));
    chk("s3_reblock0", sha_block, blk_c0);
    tick();
    req_valid = 2'b00; sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0;
    tick();

    // ---- req 1 arrives while req 0 is mid-message
    req_valid = 2'b01; req_first = 2'b01; req_last = 2'b00; req_block[0 +: 1024] = blk_f0;
    tick();
    #1;
    chk("s4_init0", strobes(), 1024'({1'b1, 1'b0, 2'b01, 2'b00}));
    tick();
    req_valid = 2'b11; req_first = 2'b10; req_last = 2'b11;
    req_block[0 +: 1024] = blk_f1; req_block[1024 +: 1024] = blk_g;
    sha_digest_valid = 1'b1;
    #1;
    chk("s4_busy_no_ready1", 1024'(req_ready), 1024'(0));
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s4_next0", strobes(), 1024'({1'b0, 1'b1, 2'b01, 2'b00}));
    chk("s4_block_f1", sha_block, blk_f1);
    tick();
    req_valid = 2'b10; sha_digest_valid = 1'b1;
    #1;
    chk("s4_busy2_no_ready1", 1024'(req_ready), 1024'(0));
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s4_rsp0", strobes(), 1024'({1'b0, 1'b0, 2'b00, 2'b01}));
    tick();
    #1;
    chk("s4_idle_no_ready1", 1024'(req_ready), 1024'(0));
    tick();
    #1;
    chk("s4_init1", strobes(), 1024'({1'b1, 1'b0, 2'b10, 2'b00}));
    chk("s4_block_g", sha_block, blk_g);
    tick();

    // ---- reset asserted in BUSY
    #1;
    chk("s5_busy_before", 1024'(busy), 1024'(1));
    rst_n = 1'b0;
    #1;
    chk("s5_rst_busy", 1024'(busy), 1024'(0));
    chk("s5_rst_owner", 1024'(owner), 1024'(0));
    chk("s5_rst_strobes", strobes(), 1024'(0));
    chk("s5_rst_digest", 1024'(rsp_digest), 1024'(0));
    tick();
    rst_n = 1'b1; req_valid = 2'b00; req_first = 2'b00;
    tick();
    sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0;
    #1;
    chk("s5_stale_no_rsp", 1024'(rsp_valid), 1024'(0));
    chk("s5_stale_idle", 1024'(busy), 1024'(0));
    tick();
    #1;
    chk("s5_stale_no_rsp2", 1024'(rsp_valid), 1024'(0));

`ifdef SHA_ARB_TIMEOUT_EN
    // ---- owner 0 stalls after its first block; req 1 waits
    req_valid = 2'b01; req_first = 2'b01; req_last = 2'b00;
    tick();
    #1;
    chk("s6_init0", strobes(), 1024'({1'b1, 1'b0, 2'b01, 2'b00}));
    tick();
    req_valid = 2'b10; req_first = 2'b10; req_last = 2'b10; sha_digest_valid = 1'b1;
    tick();
    sha_digest_valid = 1'b0;
    repeat (15) begin
      #1;
      chk("s6_no_abort_yet", 1024'(rsp_abort), 1024'(0));
      tick();
    end
    #1;
    chk("s6_no_abort_16", 1024'(rsp_abort), 1024'(0));
    tick();
    #1;
    chk("s6_abort", 1024'(rsp_abort), 1024'(2'b01));
    chk("s6_idle", 1024'(busy), 1024'(0));
    tick();
    #1;
    chk("s6_init1", strobes(), 1024'({1'b1, 1'b0, 2'b10, 2'b00}));
    chk("s6_abort_one_cycle", 1024'(rsp_abort), 1024'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrors);
    $finish;
  end

endmodule

// File: doc/sha512_core_arbiter.md
Name: sha512_core_arbiter

Overview:
- Shares one SHA-512 core (init/next/block/digest/ready interface) among NUM_REQ requesters, e.g. the HMAC controller and a raw-hash DMA client.
- Grants the core round-robin on message boundaries only. The owner keeps the core until the digest of its last block has returned.
- Sequences init for the first block and next for the following blocks, then routes the final digest back to the owner.

Parameters:
- NUM_REQ, 2, number of requesters (2..8).
- OWNER_W, 1, owner index width; must equal clog2(NUM_REQ).
- TIMEOUT_CYCLES, 1024, idle cycles allowed between an owner's blocks (used only with the optional feature).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid_i  in  NUM_REQ  requester r presents a block.
- req_first_i  in  NUM_REQ  block is the first of a message; only first blocks can win arbitration.
- req_last_i  in  NUM_REQ  block is the last of a message.
- req_block_i  in  NUM_REQ*1024  block r occupies bits [r*1024 +: 1024].
- req_ready_o  out  NUM_REQ  one-cycle accept pulse to the owner.
- rsp_valid_o  out  NUM_REQ  one-cycle final-digest pulse to the owner.
- rsp_abort_o  out  NUM_REQ  one-cycle pulse when the owner's lock is revoked by timeout.
- rsp_digest_o  out  512  last final digest, held until the next capture.
- busy_o  out  1  high whenever the state is not IDLE.
- owner_o  out  OWNER_W  current or last owner index.
- sha_init_o  out  1  core init strobe.
- sha_next_o  out  1  core next strobe.
- sha_block_o  out  1024  block to the core.
- sha_digest_i  in  512  core digest.
- sha_digest_valid_i  in  1  core digest valid.
- sha_ready_i  in  1  core idle.

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; round-robin pointer = NUM_REQ-1, so requester 0 has first priority. The core is not reset by this block; any stale sha_digest_valid_i arriving in IDLE is ignored.
- States:
  - IDLE
    - Eligible set = req_valid_i & req_first_i.
    - If non-empty, pick the first eligible index after the pointer (wrapping), register it as owner, set first_q=1, go to ISSUE.
    - The grant takes 1 cycle; no strobe is issued in IDLE.
  - ISSUE
    - Fires when sha_ready_i && req_valid_i[owner].
    - Combinationally, in that cycle:
      - sha_init_o = first_q, sha_next_o = !first_q;
      - sha_block_o = owner's block;
      - req_ready_o[owner] = 1.
    - Registered: last_q = req_last_i[owner], first_q = 0, then go to BUSY.
    - While the fire condition is false, all strobes stay 0.
    - sha_block_o is 0 outside the strobe cycle.
  - BUSY
    - Wait for sha_digest_valid_i.
    - If last_q=0: go back to ISSUE.
    - If last_q=1: rsp_digest_o <= sha_digest_i, go to RESP.
  - RESP
    - rsp_valid_o[owner] = 1 for one cycle.
    - Pointer <= owner; go to IDLE.
- Latency:
  - Request to first strobe: 2 cycles minimum (IDLE, ISSUE).
  - Final digest_valid to rsp_valid_o: 1 cycle.
- Within ISSUE, req_first_i is ignored; init versus next is decided only by first_q. A single-block message sets first and last together.
- Non-owner requests, and requests with req_first_i=0 while in IDLE, are never accepted and never get a req_ready_o pulse.
- The owner changes only in IDLE. A new request arriving during RESP is arbitrated in the following IDLE cycle.
- Simultaneous requests: strict round-robin. After owner k finishes, k+1..NUM_REQ-1 and then 0..k are searched.
- rst_n asserted mid-message: immediate return to IDLE. No rsp_valid_o is issued and the owner must restart its message.

Optional Feature:
- Macro: SHA_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears on every ISSUE fire and increments each cycle the FSM sits in ISSUE with first_q=0.
  - On reaching TIMEOUT_CYCLES: rsp_abort_o[owner] pulses for 1 cycle, pointer <= owner, state goes to IDLE.
  - The core is left mid-message; the next grant re-inits it.
- Not defined: no counter is built, rsp_abort_o is tied to 0, and the owner can hold the core indefinitely.

Test Plan:
- Single-block message: req 0 valid, first=1, last=1, block=A → sha_init_o one pulse carrying A. A core digest D arrives 80 cycles later → rsp_valid_o=2'b01 one cycle after it, rsp_digest_o=D, busy_o=0 on the following cycle.
- Three-block message from req 1 → strobe sequence init, next, next, each only while sha_ready_i=1. Three req_ready_o[1] pulses and exactly one rsp_valid_o[1].
- req 0 and req 1 assert first at the same cycle after reset → req 0 is served first and req 1 second. Both then re-request → req 0 first again, because the pointer is 1 after req 1 finishes.
- Req 1 raises first=1 while req 0 is mid-message → req 1 gets no req_ready_o until rsp_valid_o[0] has pulsed. Req 1's strobe is init, not next.
- rst_n pulled low during BUSY → all outputs 0 within the same cycle. A core digest_valid arriving later produces no rsp_valid_o.
- With SHA_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16: owner stalls after its first block → rsp_abort_o pulses at 16 cycles of ISSUE stall. Another pending requester is then granted, with sha_init_o.
